// File: rtl/tinker_mem_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, transaction
// owner and the default timing parameters.
package tinker_mem_pkg;

   // Transaction phases; one transaction is outstanding at a time.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   // Which requester owns the transaction in flight.
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   localparam int LAT_DEFAULT        = 2;
   localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational priority decision between the fetch and data requesters.
// Data wins by default; fetch wins a contested cycle once it has been
// passed over STARVE_MAX times in a row.
module mem_arb_select
   import tinker_mem_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic       if_valid,
   input  logic       d_valid,
   input  logic [2:0] starve_cnt,
   output logic       grant_if,
   output logic       grant_d
);

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   // Pick at most one winner from the currently valid requests.
   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (if_valid && d_valid) begin
         if (starve_cnt == STARVE_LIM) begin
            grant_if = 1'b1;
         end else begin
            grant_d = 1'b1;
         end
      end else if (d_valid) begin
         grant_d = 1'b1;
      end else if (if_valid) begin
         grant_if = 1'b1;
      end else begin
         grant_if = 1'b0;
         grant_d  = 1'b0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between an instruction-fetch and a
// data requester. One transaction in flight: accept in IDLE, one-cycle
// strobe in ISSUE, LAT cycles in WAIT, one-cycle response pulse in RESP.
module mem_port_arbiter
   import tinker_mem_pkg::*;
#(
   parameter int LAT        = LAT_DEFAULT,
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [63:0] if_addr,
   output logic        if_resp_valid,
   output logic [31:0] if_resp_data,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic        d_we,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic        d_resp_valid,
   output logic [63:0] d_resp_data,
   output logic        mem_en,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata
);

   // WAIT counts down from LAT-1 to 0; capture happens on the zero cycle.
   localparam logic [2:0] WAIT_LAST = 3'(LAT - 1);

   arb_state_e state_r;
   owner_e     owner_r;
   logic       we_r;
   logic [2:0] starve_cnt_r;
   logic [2:0] wait_cnt_r;
   logic       grant_if_s;
   logic       grant_d_s;

   mem_arb_select #(
      .STARVE_MAX (STARVE_MAX)
   ) u_select (
      .if_valid   (if_req_valid),
      .d_valid    (d_req_valid),
      .starve_cnt (starve_cnt_r),
      .grant_if   (grant_if_s),
      .grant_d    (grant_d_s)
   );

   // Ready goes only to the winner, only in IDLE, and never while in reset.
   always_comb begin
      if_req_ready = 1'b0;
      d_req_ready  = 1'b0;
      if (reset && (state_r == IDLE)) begin
         if_req_ready = grant_if_s;
         d_req_ready  = grant_d_s;
      end else begin
         if_req_ready = 1'b0;
         d_req_ready  = 1'b0;
      end
   end

   // Transaction FSM with request latches, starvation counter and
   // registered memory/response outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         owner_r       <= OWN_IF;
         we_r          <= 1'b0;
         starve_cnt_r  <= 3'd0;
         wait_cnt_r    <= 3'd0;
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= 64'd0;
         mem_wdata     <= 64'd0;
         if_resp_valid <= 1'b0;
         if_resp_data  <= 32'd0;
         d_resp_valid  <= 1'b0;
         d_resp_data   <= 64'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_if_s) begin
                  owner_r      <= OWN_IF;
                  we_r         <= 1'b0;
                  mem_addr     <= if_addr;
                  mem_wdata    <= 64'd0;
                  mem_we       <= 1'b0;
                  mem_en       <= 1'b1;
                  starve_cnt_r <= 3'd0;
                  state_r      <= ISSUE;
               end else if (grant_d_s) begin
                  owner_r      <= OWN_D;
                  we_r         <= d_we;
                  mem_addr     <= d_addr;
                  mem_wdata    <= d_we ? d_wdata : 64'd0;
                  mem_we       <= d_we;
                  mem_en       <= 1'b1;
                  // Only a data win over a waiting fetch counts as starvation.
                  starve_cnt_r <= if_req_valid ? (starve_cnt_r + 3'd1) : 3'd0;
                  state_r      <= ISSUE;
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               mem_en     <= 1'b0;
               mem_we     <= 1'b0;
               mem_wdata  <= 64'd0;
               wait_cnt_r <= WAIT_LAST;
               state_r    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt_r == 3'd0) begin
                  if (owner_r == OWN_IF) begin
                     if_resp_valid <= 1'b1;
                     if_resp_data  <= mem_rdata[31:0];
                  end else begin
                     d_resp_valid <= 1'b1;
                     d_resp_data  <= we_r ? 64'd0 : mem_rdata;
                  end
                  state_r <= RESP;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 3'd1;
               end
            end
            RESP: begin
               if_resp_valid <= 1'b0;
               d_resp_valid  <= 1'b0;
               state_r       <= IDLE;
            end
            default: begin
               mem_en        <= 1'b0;
               mem_we        <= 1'b0;
               if_resp_valid <= 1'b0;
               d_resp_valid  <= 1'b0;
               state_r       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: randomized and directed requests checked
// against a transaction-level reference model and a behavioural memory.
module tb_mem_port_arbiter;

   localparam int LAT        = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req_valid = 1'b0;
   logic        if_req_ready;
   logic [63:0] if_addr = 64'd0;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        d_req_valid = 1'b0;
   logic        d_req_ready;
   logic        d_we = 1'b0;
   logic [63:0] d_addr = 64'd0;
   logic [63:0] d_wdata = 64'd0;
   logic        d_resp_valid;
   logic [63:0] d_resp_data;
   logic        mem_en;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata = 64'd0;

   mem_port_arbiter #(.LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   // Behavioural memory seen through the DUT port, and the model's view.
   logic [63:0] env_mem [logic [63:0]];
   logic [63:0] ref_mem [logic [63:0]];
   int          rd_due = -1;
   logic [63:0] rd_data = 64'd0;

   // Reference model state (transaction level).
   int          next_idle = 0;
   int          starve = 0;
   int          exp_mem_cycle = -1;
   logic [63:0] exp_mem_addr = 64'd0;
   logic        exp_mem_we = 1'b0;
   logic [63:0] exp_mem_wdata = 64'd0;
   int          exp_resp_cycle = -1;
   logic        exp_owner_d = 1'b0;
   logic [63:0] exp_resp_data = 64'd0;
   logic [31:0] last_if = 32'd0;
   logic [63:0] last_d = 64'd0;

   logic [9:0]  grants = 10'd0;
   int          n_grants = 0;

   logic [63:0] pool [8] = '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_1008,
                             64'h0000_0000_0000_2000, 64'h0000_0000_0000_2004,
                             64'hFFFF_FFFF_FFFF_FFF8, 64'h8000_0000_0000_0003,
                             64'h0000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mem_init(input logic [63:0] a);
      logic [63:0] v;
      v = {a[31:0] ^ 32'h5A5A_1234, ~a[31:0] ^ 32'h0F0F_0F0F};
      return v;
   endfunction

   function automatic logic [63:0] env_read(input logic [63:0] a);
      if (env_mem.exists(a)) return env_mem[a];
      return mem_init(a);
   endfunction

   function automatic logic [63:0] ref_read(input logic [63:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return mem_init(a);
   endfunction

   function automatic logic [63:0] rnd64();
      logic [63:0] v;
      v = {$urandom, $urandom};
      return v;
   endfunction

   // One clock cycle: check registered outputs, drive inputs, check
   // arbitration, advance the model, then move to the next cycle.
   task automatic step(input logic iv, input logic [63:0] ia, input logic dv,
                       input logic dw, input logic [63:0] da, input logic [63:0] dwd);
      logic        exp_en;
      logic        win_if;
      logic        win_d;
      logic [63:0] fw;
      exp_en = (cyc == exp_mem_cycle);
      chk("mem_en", 64'(mem_en), 64'(exp_en));
      chk("mem_we", 64'(mem_we), 64'(exp_en && exp_mem_we));
      if (exp_en) begin
         chk("mem_addr", mem_addr, exp_mem_addr);
         chk("mem_wdata", mem_wdata, exp_mem_wdata);
      end
      if (cyc == exp_resp_cycle) begin
         if (exp_owner_d) last_d = exp_resp_data;
         else last_if = exp_resp_data[31:0];
      end
      chk("if_resp_valid", 64'(if_resp_valid), 64'((cyc == exp_resp_cycle) && !exp_owner_d));
      chk("d_resp_valid", 64'(d_resp_valid), 64'((cyc == exp_resp_cycle) && exp_owner_d));
      chk("if_resp_data", 64'(if_resp_data), 64'(last_if));
      chk("d_resp_data", d_resp_data, last_d);
      if (mem_en) begin
         if (mem_we) env_mem[mem_addr] = mem_wdata;
         else begin
            rd_due  = cyc + LAT;
            rd_data = env_read(mem_addr);
         end
      end
      if_req_valid = iv; if_addr = ia;
      d_req_valid = dv; d_we = dw; d_addr = da; d_wdata = dwd;
      mem_rdata = (cyc == rd_due) ? rd_data : rnd64();
      #1;
      if (exp_en) chk("mem_addr_hold", mem_addr, exp_mem_addr);
      win_if = 1'b0;
      win_d  = 1'b0;
      if (cyc >= next_idle) begin
         if (iv && dv) begin
            if (starve == STARVE_MAX) win_if = 1'b1;
            else win_d = 1'b1;
         end else begin
            win_if = iv;
            win_d  = dv;
         end
      end
      chk("if_req_ready", 64'(if_req_ready), 64'(win_if));
      chk("d_req_ready", 64'(d_req_ready), 64'(win_d));
      if (win_if || win_d) begin
         grants = {grants[8:0], d_req_ready};
         n_grants++;
         exp_mem_cycle  = cyc + 1;
         exp_resp_cycle = cyc + LAT + 2;
         next_idle      = cyc + LAT + 3;
         exp_owner_d    = win_d;
         if (win_if) begin
            exp_mem_addr  = ia;
            exp_mem_we    = 1'b0;
            exp_mem_wdata = 64'd0;
            fw = ref_read(ia);
            exp_resp_data = {32'd0, fw[31:0]};
            starve = 0;
         end else begin
            exp_mem_addr  = da;
            exp_mem_we    = dw;
            exp_mem_wdata = dw ? dwd : 64'd0;
            if (dw) begin
               exp_resp_data = 64'd0;
               ref_mem[da] = dwd;
            end else begin
               exp_resp_data = ref_read(da);
            end
            starve = iv ? starve + 1 : 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_step();
      step(1'b0, rnd64(), 1'b0, 1'b0, rnd64(), rnd64());
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_strobes"}, 64'({if_req_ready, d_req_ready, if_resp_valid,
                                  d_resp_valid, mem_en, mem_we}), 64'd0);
      chk({tag, "_if_data"}, 64'(if_resp_data), 64'd0);
      chk({tag, "_d_data"}, d_resp_data, 64'd0);
      chk({tag, "_mem_addr"}, mem_addr, 64'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
   endtask

   // Called at posedge+1; leaves reset released at posedge+1 of a fresh cycle.
   task automatic do_reset();
      reset = 1'b0;
      if_req_valid = 1'b1;
      d_req_valid = 1'b1;
      #1;
      check_outputs_zero("rst_async");
      @(posedge clk);
      #1;
      cyc++;
      check_outputs_zero("rst_hold");
      if_req_valid = 1'b0;
      d_req_valid = 1'b0;
      reset = 1'b1;
      next_idle = cyc;
      starve = 0;
      exp_mem_cycle = -1;
      exp_resp_cycle = -1;
      last_if = 32'd0;
      last_d = 64'd0;
      rd_due = -1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // Lone fetch: response 4 cycles after the accept cycle.
      env_mem[64'h2000] = 64'h1122_3344_AABB_CCDD;
      ref_mem[64'h2000] = 64'h1122_3344_AABB_CCDD;
      step(1'b1, 64'h2000, 1'b0, 1'b0, rnd64(), rnd64());
      repeat (3) idle_step();
      chk("lone_fetch_valid", 64'(if_resp_valid), 64'd1);
      chk("lone_fetch_data", 64'(if_resp_data), 64'h0000_0000_AABB_CCDD);
      repeat (2) idle_step();

      // Write then load the same address; address change after accept.
      step(1'b0, rnd64(), 1'b1, 1'b1, 64'h1000, 64'h0000_0000_DEAD_BEEF);
      repeat (LAT + 2) idle_step();
      step(1'b0, rnd64(), 1'b1, 1'b0, 64'h1000, rnd64());
      step(1'b0, rnd64(), 1'b1, 1'b0, 64'h3000, rnd64());
      repeat (2) idle_step();
      chk("load_valid", 64'(d_resp_valid), 64'd1);
      chk("load_data", d_resp_data, 64'h0000_0000_DEAD_BEEF);
      repeat (2) idle_step();

      // Both requesters continuously valid from a cleared starvation count.
      do_reset();
      grants = 10'd0;
      n_grants = 0;
      for (int i = 0; i < 80 && n_grants < 10; i++) begin
         step(1'b1, pool[$urandom_range(0, 7)], 1'b1, 1'($urandom_range(0, 1)),
              pool[$urandom_range(0, 7)], rnd64());
      end
      chk("grant_order", 64'(grants), 64'(10'b11110_11110));
      repeat (LAT + 3) idle_step();

      // Reset during WAIT discards the fetch; fresh accept right after.
      step(1'b1, 64'h2000, 1'b0, 1'b0, rnd64(), rnd64());
      idle_step();
      idle_step();
      do_reset();
      step(1'b1, 64'h2004, 1'b0, 1'b0, rnd64(), rnd64());
      repeat (LAT + 3) idle_step();

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 99) < 55), pool[$urandom_range(0, 7)],
              1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
              pool[$urandom_range(0, 7)], rnd64());
      end
      repeat (LAT + 3) idle_step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LAT, default 2, range 1..7: fixed memory read latency in cycles, counted from the mem_en cycle to the cycle mem_rdata is valid.
REQ-002 Parameter STARVE_MAX, default 4, range 1..7: maximum consecutive data grants while a fetch request waits.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port if_req_valid, input, 1: fetch request pending.
REQ-006 Port if_req_ready, output, 1: fetch request accepted this cycle.
REQ-007 Port if_addr, input, 64: fetch byte address.
REQ-008 Port if_resp_valid, output, 1: one-cycle fetch response pulse.
REQ-009 Port if_resp_data, output, 32: instruction word.
REQ-010 Port d_req_valid, input, 1: data request pending.
REQ-011 Port d_req_ready, output, 1: data request accepted this cycle.
REQ-012 Port d_we, input, 1: data request is a write.
REQ-013 Port d_addr, input, 64: data byte address.
REQ-014 Port d_wdata, input, 64: store data.
REQ-015 Port d_resp_valid, output, 1: one-cycle data response pulse; this is the load data or the write acknowledge.
REQ-016 Port d_resp_data, output, 64: load data; zero for writes.
REQ-017 Port mem_en, output, 1: memory access strobe.
REQ-018 Port mem_we, output, 1: memory write strobe.
REQ-019 Port mem_addr, output, 64: memory address.
REQ-020 Port mem_wdata, output, 64: memory write data.
REQ-021 Port mem_rdata, input, 64: memory read data.

Function
REQ-022 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, with one transaction outstanding at a time.
REQ-023 In IDLE, exactly one of if_req_ready and d_req_ready SHALL be asserted combinationally for the arbitration winner; both SHALL be 0 in all other states.
REQ-024 Arbitration SHALL grant data over fetch, except that when starve_cnt equals STARVE_MAX and both requests are valid, fetch SHALL win.
REQ-025 starve_cnt SHALL increment on a data grant when if_req_valid=1, and SHALL clear on a fetch grant or on a data grant with if_req_valid=0.
REQ-026 On an accept edge (valid and ready both 1), the block SHALL latch owner, address, we and wdata, then move to ISSUE.
REQ-027 In ISSUE, the block SHALL drive mem_en=1 for exactly one cycle with the latched address; mem_we and mem_wdata SHALL be driven only for data writes, and fetch drives mem_we=0.
REQ-028 WAIT SHALL last exactly LAT cycles; on the final edge, mem_rdata SHALL be captured and the FSM SHALL move to RESP.
REQ-029 In RESP, the owner's resp_valid SHALL be 1 for one cycle and the FSM SHALL return to IDLE.
REQ-030 Response timing SHALL be LAT+2 cycles from the accept edge to resp_valid high, with one accept at most every LAT+3 cycles.
REQ-031 if_resp_data SHALL equal captured mem_rdata[31:0]; d_resp_data SHALL equal captured mem_rdata for loads and 0 for writes.
REQ-032 resp_data outputs SHALL hold their last value outside RESP; the non-owner's resp_valid SHALL stay 0.
REQ-033 Request inputs SHALL be ignored outside IDLE; changes to them after accept SHALL not affect the transaction in flight.
REQ-034 Both valids low in IDLE SHALL leave all state unchanged, with mem_en=0.
REQ-035 Addresses SHALL pass through unmodified, with no alignment check and no wrap handling; the 64-bit value goes directly to mem_addr.

Reset
REQ-036 While reset=0, the FSM SHALL be in IDLE, starve_cnt=0, and all outputs 0, including both ready signals.
REQ-037 A transaction in flight at reset assertion SHALL be discarded: no resp pulse, and no mem_en after reset.
REQ-038 The first accept SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-039 Shared package tinker_mem_pkg SHALL hold the FSM state enum, the owner enum (OWN_IF, OWN_D), and the LAT/STARVE_MAX defaults.
REQ-040 One sub-module, mem_arb_select, SHALL hold the combinational priority and starvation decision; the FSM, latches and counters stay in mem_port_arbiter.

Verification
REQ-041 Lone fetch, LAT=2, if_addr=0x2000, memory returns 0x11223344_AABBCCDD -> if_resp_valid 4 cycles after accept, if_resp_data=0xAABBCCDD.
REQ-042 Data write to 0x1000 with 0xDEADBEEF, then load from 0x1000 -> write ack with d_resp_data=0, then load response 0xDEADBEEF; mem_we high only in the write's ISSUE cycle.
REQ-043 Fetch and data valid continuously, STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-044 Simultaneous first requests with starve_cnt=0 -> data granted and if_req_ready=0 that cycle.
REQ-045 Reset asserted during WAIT -> no resp_valid pulse, all outputs 0, fresh accept on the first cycle after release.
REQ-046 d_addr changed in the cycle after accept -> mem_addr equals the originally accepted address.
